// File: rtl/sharpen_ctrl_pkg.sv
// Shared definitions for the image-sharpening sequencer:
// FSM state encoding, pixel/accumulator widths and kernel weights.
package sharpen_ctrl_pkg;

   localparam int PIX_W = 8;
   localparam int ACC_W = 12;
   localparam int K_C   = 5;
   localparam int K_N   = 1;

   typedef enum logic [3:0] {
      IDLE,
      RD_C,
      RD_N,
      RD_S,
      RD_W,
      RD_E,
      CALC,
      WR,
      NEXT,
      DONE
   } state_e;

endpackage

// File: rtl/sharpen_ctrl_alu.sv
// Sharpen kernel: res = clamp(5*C - N - S - W - E, 0, 255).
// Ports: c_i/n_i/s_i/w_i/e_i cross pixels in, res_o clamped pixel out.
module sharpen_ctrl_alu
   import sharpen_ctrl_pkg::*;
(
   input  logic [PIX_W-1:0] c_i,
   input  logic [PIX_W-1:0] n_i,
   input  logic [PIX_W-1:0] s_i,
   input  logic [PIX_W-1:0] w_i,
   input  logic [PIX_W-1:0] e_i,
   output logic [PIX_W-1:0] res_o
);

   logic [ACC_W-1:0] pos;
   logic [ACC_W-1:0] neg;
   logic [ACC_W-1:0] acc;

   always_comb begin
      pos = ACC_W'(K_C) * ACC_W'(c_i);
      neg = ACC_W'(K_N) * (ACC_W'(n_i) + ACC_W'(s_i)
                         + ACC_W'(w_i) + ACC_W'(e_i));
      // Range -1020..1275 fits 12-bit two's complement.
      acc = pos - neg;
      if (acc[ACC_W-1]) begin
         res_o = '0;
      end else if (|acc[ACC_W-2:PIX_W]) begin
         res_o = '1;
      end else begin
         res_o = acc[PIX_W-1:0];
      end
   end

endmodule

// File: rtl/sharpen_ctrl.sv
// Raster-order sharpen sequencer; single memory master.
// Ports: start/src_base/dst_base, busy/done, mem_req/we/addr/wdata/ack/rdata.
module sharpen_ctrl
   import sharpen_ctrl_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   output logic              busy,
   output logic              done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata
);

   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WIDTH);
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [ADDR_W-1:0] off_q, off_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [7:0]        c_q, c_d, n_q, n_d, s_q, s_d;
   logic [7:0]        w_q, w_d, e_q, e_d;
   logic              req_q, req_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wd_q, wd_d;

   logic              border, last;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        alu_res;

   sharpen_ctrl_alu u_alu (
      .c_i   (c_q),
      .n_i   (n_q),
      .s_i   (s_q),
      .w_i   (w_q),
      .e_i   (e_q),
      .res_o (alu_res)
   );

   assign border = (row_q == '0) || (row_q == ROW_LAST)
                || (col_q == '0) || (col_q == COL_LAST);
   assign last   = (row_q == ROW_LAST) && (col_q == COL_LAST);

   always_comb begin
      unique case (state_q)
         RD_N:    rd_addr = src_q + off_q - STRIDE;
         RD_S:    rd_addr = src_q + off_q + STRIDE;
         RD_W:    rd_addr = src_q + off_q - ONE;
         RD_E:    rd_addr = src_q + off_q + ONE;
         default: rd_addr = src_q + off_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      off_d   = off_q;
      col_d   = col_q;
      row_d   = row_q;
      c_d     = c_q;
      n_d     = n_q;
      s_d     = s_q;
      w_d     = w_q;
      e_d     = e_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               src_d   = src_base;
               dst_d   = dst_base;
               off_d   = '0;
               col_d   = '0;
               row_d   = '0;
               state_d = RD_C;
            end
         end
         RD_C, RD_N, RD_S, RD_W, RD_E: begin
            // req low on entry gives the idle gap between transactions
            if (!req_q) begin
               req_d  = 1'b1;
               we_d   = 1'b0;
               addr_d = rd_addr;
            end else if (mem_ack) begin
               req_d = 1'b0;
               unique case (state_q)
                  RD_C: begin
                     c_d = mem_rdata;
                     if (border) begin
                        wd_d    = mem_rdata;
                        state_d = WR;
                     end else begin
                        state_d = RD_N;
                     end
                  end
                  RD_N: begin
                     n_d     = mem_rdata;
                     state_d = RD_S;
                  end
                  RD_S: begin
                     s_d     = mem_rdata;
                     state_d = RD_W;
                  end
                  RD_W: begin
                     w_d     = mem_rdata;
                     state_d = RD_E;
                  end
                  default: begin
                     e_d     = mem_rdata;
                     state_d = CALC;
                  end
               endcase
            end
         end
         CALC: begin
            wd_d    = alu_res;
            state_d = WR;
         end
         WR: begin
            if (!req_q) begin
               req_d  = 1'b1;
               we_d   = 1'b1;
               addr_d = dst_q + off_q;
            end else if (mem_ack) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = NEXT;
            end
         end
         NEXT: begin
            off_d = off_q + ONE;
            if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = row_q + RW'(1);
            end else begin
               col_d = col_q + CW'(1);
            end
            state_d = last ? DONE : RD_C;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         off_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         c_q     <= '0;
         n_q     <= '0;
         s_q     <= '0;
         w_q     <= '0;
         e_q     <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         off_q   <= off_d;
         col_q   <= col_d;
         row_q   <= row_d;
         c_q     <= c_d;
         n_q     <= n_d;
         s_q     <= s_d;
         w_q     <= w_d;
         e_q     <= e_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
      end
   end

   assign busy      = (state_q != IDLE) && (state_q != DONE);
   assign done      = (state_q == DONE);
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wd_q;

endmodule

// File: tb/tb_sharpen_ctrl.sv
// Bench for sharpen_ctrl: 4x3 and 3x3 instances on a
// behavioural memory with configurable ack latency.
module tb_sharpen_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start [2] = '{1'b0, 1'b0};
   logic [15:0] sbase [2] = '{16'h0, 16'h0};
   logic [15:0] dbase [2] = '{16'h0, 16'h0};
   logic        busy  [2];
   logic        done  [2];
   logic        req   [2];
   logic        we    [2];
   logic [15:0] addr  [2];
   logic [7:0]  wdata [2];
   logic        ack   [2] = '{1'b0, 1'b0};
   logic [7:0]  rdata [2] = '{8'h0, 8'h0};

   sharpen_ctrl #(.WIDTH(4), .HEIGHT(3), .ADDR_W(16)) u_a (
      .clk(clk), .reset(reset), .start(start[0]),
      .src_base(sbase[0]), .dst_base(dbase[0]),
      .busy(busy[0]), .done(done[0]),
      .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
      .mem_wdata(wdata[0]), .mem_ack(ack[0]), .mem_rdata(rdata[0])
   );

   sharpen_ctrl #(.WIDTH(3), .HEIGHT(3), .ADDR_W(16)) u_b (
      .clk(clk), .reset(reset), .start(start[1]),
      .src_base(sbase[1]), .dst_base(dbase[1]),
      .busy(busy[1]), .done(done[1]),
      .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
      .mem_wdata(wdata[1]), .mem_ack(ack[1]), .mem_rdata(rdata[1])
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [0:65535];
   int          vectors = 0;
   int          errs = 0;
   int          ack_delay = 0;
   int          acks_left = -1;
   bit          act [2];
   int          cnt [2];
   logic [15:0] h_addr [2];
   logic        h_we [2];
   logic [7:0]  h_wd [2];
   bit          done_prev [2];
   int          dcnt [2];
   logic [15:0] wq_addr [$];
   logic [7:0]  wq_data [$];
   logic [15:0] ex_addr [$];
   logic [7:0]  ex_data [$];
   logic [7:0]  saved [$];

   // memory responder: one request at a time, ack after ack_delay waits
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            ack[i] = 1'b0;
            act[i] = 1'b0;
         end else if (ack[i]) begin
            ack[i] = 1'b0;
            vectors++;
            if (req[i] !== 1'b0) begin
               errs++;
               $display("FAIL req_gap dut%0d req=%b want 0", i, req[i]);
            end
         end else if (req[i]) begin
            if (!act[i]) begin
               act[i]    = 1'b1;
               cnt[i]    = ack_delay;
               h_addr[i] = addr[i];
               h_we[i]   = we[i];
               h_wd[i]   = wdata[i];
            end else begin
               vectors++;
               if (addr[i] !== h_addr[i] || we[i] !== h_we[i]
                   || (we[i] && wdata[i] !== h_wd[i])) begin
                  errs++;
                  $display("FAIL hold dut%0d addr=%h we=%b wd=%h want %h %b %h",
                           i, addr[i], we[i], wdata[i],
                           h_addr[i], h_we[i], h_wd[i]);
               end
            end
            if (cnt[i] == 0 && acks_left != 0) begin
               ack[i]   = 1'b1;
               rdata[i] = mem[addr[i]];
               if (we[i]) begin
                  mem[addr[i]] = wdata[i];
                  wq_addr.push_back(addr[i]);
                  wq_data.push_back(wdata[i]);
               end
               if (acks_left > 0) acks_left--;
               act[i] = 1'b0;
            end else if (cnt[i] > 0) begin
               cnt[i]--;
            end
         end
         if (done[i]) dcnt[i]++;
         vectors++;
         if (done[i] && done_prev[i]) begin
            errs++;
            $display("FAIL done_width dut%0d done=1 two cycles want 1", i);
         end
         done_prev[i] = done[i];
      end
   end

   function automatic logic [7:0] ref_px(logic [15:0] src, int w,
                                         int h, int r, int c);
      logic [15:0] p;
      int v;
      p = src + 16'(r * w + c);
      if (r == 0 || r == h - 1 || c == 0 || c == w - 1) return mem[p];
      v = 5 * int'(mem[p]) - int'(mem[p - 16'(w)])
        - int'(mem[p + 16'(w)]) - int'(mem[p - 16'd1])
        - int'(mem[p + 16'd1]);
      if (v < 0) return 8'd0;
      if (v > 255) return 8'd255;
      return v[7:0];
   endfunction

   task automatic build_exp(logic [15:0] s, logic [15:0] d, int w, int h);
      ex_addr.delete();
      ex_data.delete();
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            ex_addr.push_back(d + 16'(r * w + c));
            ex_data.push_back(ref_px(s, w, h, r, c));
         end
   endtask

   task automatic fill_rand(logic [15:0] s, int n);
      for (int k = 0; k < n; k++) mem[s + 16'(k)] = 8'($urandom);
   endtask

   task automatic fill_const(logic [15:0] s, int n, logic [7:0] v);
      for (int k = 0; k < n; k++) mem[s + 16'(k)] = v;
   endtask

   task automatic launch(int i, logic [15:0] s, logic [15:0] d);
      wq_addr.delete();
      wq_data.delete();
      dcnt[i] = 0;
      @(negedge clk);
      sbase[i] = s;
      dbase[i] = d;
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
   endtask

   task automatic wait_done(int i, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (done[i]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if ({busy[i], done[i], req[i], we[i], addr[i], wdata[i]} !== 28'h0) begin
            errs++;
            $display("FAIL reset_out dut%0d got %b%b%b%b %h %h want all 0",
                     i, busy[i], done[i], req[i], we[i], addr[i], wdata[i]);
         end
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (busy[i] !== 1'b0 || req[i] !== 1'b0) begin
            errs++;
            $display("FAIL idle_out dut%0d busy=%b req=%b want 0 0",
                     i, busy[i], req[i]);
         end
      end
   endtask

   task automatic test_flat();
      bit ok;
      fill_const(16'h0000, 9, 8'd100);
      launch(1, 16'h0000, 16'h0100);
      wait_done(1, ok);
      repeat (2) @(negedge clk);
      vectors++;
      if (!ok) begin errs++; $display("FAIL flat_timeout done=0 want 1"); end
      vectors++;
      if (wq_addr.size() != 9) begin
         errs++;
         $display("FAIL flat_count got %0d want 9", wq_addr.size());
      end
      for (int k = 0; k < wq_addr.size() && k < 9; k++) begin
         vectors++;
         if (wq_addr[k] !== 16'h0100 + 16'(k) || wq_data[k] !== 8'd100) begin
            errs++;
            $display("FAIL flat_wr%0d got %h:%0d want %h:100",
                     k, wq_addr[k], wq_data[k], 16'h0100 + 16'(k));
         end
      end
      vectors++;
      if (dcnt[1] != 1) begin
         errs++;
         $display("FAIL flat_done got %0d pulses want 1", dcnt[1]);
      end
   endtask

   task automatic test_clamp();
      logic [7:0] ctr [2] = '{8'd200, 8'd0};
      logic [7:0] nb  [2] = '{8'd10, 8'd255};
      logic [7:0] want [2] = '{8'd255, 8'd0};
      bit ok;
      for (int t = 0; t < 2; t++) begin
         fill_const(16'h0400, 9, nb[t]);
         mem[16'h0404] = ctr[t];
         launch(1, 16'h0400, 16'h0500);
         wait_done(1, ok);
         repeat (2) @(negedge clk);
         vectors++;
         if (!ok || wq_data.size() != 9) begin
            errs++;
            $display("FAIL clamp%0d_run done=%b writes=%0d want 1 9",
                     t, ok, wq_data.size());
         end else begin
            for (int k = 0; k < 9; k++) begin
               vectors++;
               if (wq_data[k] !== (k == 4 ? want[t] : nb[t])) begin
                  errs++;
                  $display("FAIL clamp%0d_px%0d got %0d want %0d", t, k,
                           wq_data[k], (k == 4 ? want[t] : nb[t]));
               end
            end
         end
      end
   endtask

   task automatic test_raster(int delay, bit keep);
      bit ok;
      ack_delay = delay;
      if (keep == 1'b0) fill_rand(16'h0200, 12);
      build_exp(16'h0200, 16'h0300, 4, 3);
      launch(0, 16'h0200, 16'h0300);
      wait_done(0, ok);
      repeat (2) @(negedge clk);
      vectors++;
      if (!ok || wq_addr.size() != 12) begin
         errs++;
         $display("FAIL raster_d%0d_run done=%b writes=%0d want 1 12",
                  delay, ok, wq_addr.size());
      end else begin
         for (int k = 0; k < 12; k++) begin
            vectors++;
            if (wq_addr[k] !== ex_addr[k] || wq_data[k] !== ex_data[k]) begin
               errs++;
               $display("FAIL raster_d%0d_wr%0d got %h:%h want %h:%h", delay,
                        k, wq_addr[k], wq_data[k], ex_addr[k], ex_data[k]);
            end
            if (keep) begin
               vectors++;
               if (wq_data[k] !== saved[k]) begin
                  errs++;
                  $display("FAIL backpressure_wr%0d got %h want %h",
                           k, wq_data[k], saved[k]);
               end
            end
         end
         saved = wq_data;
      end
      vectors++;
      if (dcnt[0] != 1) begin
         errs++;
         $display("FAIL raster_d%0d_done got %0d want 1", delay, dcnt[0]);
      end
      ack_delay = 0;
   endtask

   task automatic test_back_to_back();
      bit ok;
      fill_rand(16'h0200, 12);
      fill_rand(16'h0600, 12);
      build_exp(16'h0200, 16'h0300, 4, 3);
      launch(0, 16'h0200, 16'h0300);
      repeat (6) @(negedge clk);
      start[0] = 1'b1;
      sbase[0] = 16'h1000;
      dbase[0] = 16'h2000;
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, ok);
      vectors++;
      if (!ok || wq_addr.size() != 12) begin
         errs++;
         $display("FAIL busy_start_run done=%b writes=%0d want 1 12",
                  ok, wq_addr.size());
      end else begin
         for (int k = 0; k < 12; k++) begin
            vectors++;
            if (wq_addr[k] !== ex_addr[k] || wq_data[k] !== ex_data[k]) begin
               errs++;
               $display("FAIL busy_start_wr%0d got %h:%h want %h:%h",
                        k, wq_addr[k], wq_data[k], ex_addr[k], ex_data[k]);
            end
         end
      end
      @(negedge clk);
      vectors++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0 || dcnt[0] != 1) begin
         errs++;
         $display("FAIL done_pulse done=%b busy=%b pulses=%0d want 0 0 1",
                  done[0], busy[0], dcnt[0]);
      end
      build_exp(16'h0600, 16'h0700, 4, 3);
      wq_addr.delete();
      wq_data.delete();
      dcnt[0] = 0;
      start[0] = 1'b1;
      sbase[0] = 16'h0600;
      dbase[0] = 16'h0700;
      @(negedge clk);
      start[0] = 1'b0;
      vectors++;
      if (busy[0] !== 1'b1) begin
         errs++;
         $display("FAIL b2b_accept busy=%b want 1", busy[0]);
      end
      wait_done(0, ok);
      repeat (2) @(negedge clk);
      vectors++;
      if (!ok || wq_addr.size() != 12) begin
         errs++;
         $display("FAIL b2b_run done=%b writes=%0d want 1 12",
                  ok, wq_addr.size());
      end else begin
         for (int k = 0; k < 12; k++) begin
            vectors++;
            if (wq_addr[k] !== ex_addr[k] || wq_data[k] !== ex_data[k]) begin
               errs++;
               $display("FAIL b2b_wr%0d got %h:%h want %h:%h",
                        k, wq_addr[k], wq_data[k], ex_addr[k], ex_data[k]);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      bit hit;
      fill_rand(16'h0200, 12);
      acks_left = 12;
      launch(0, 16'h0200, 16'h0300);
      hit = 1'b0;
      for (int k = 0; k < 500 && !hit; k++) begin
         @(negedge clk);
         if (req[0] && addr[0] == 16'h0209) hit = 1'b1;
      end
      vectors++;
      if (!hit) begin
         errs++;
         $display("FAIL midreset_rd_s addr=%h want 0209 pending", addr[0]);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy[0] !== 1'b0 || req[0] !== 1'b0 || done[0] !== 1'b0) begin
         errs++;
         $display("FAIL midreset_out busy=%b req=%b done=%b want 0 0 0",
                  busy[0], req[0], done[0]);
      end
      reset = 1'b0;
      acks_left = -1;
      @(negedge clk);
      test_raster(0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_flat();
      test_clamp();
      for (int n = 0; n < 3; n++) test_raster(0, 1'b0);
      test_raster(3, 1'b1);
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
